act_row_cache: RTL and testbench
================================

Name: act_row_cache

Overview:
- Parametrised activation row cache: a circular buffer of DEPTH rows of DATA_WIDTH bits, written by the activation loader and read by the PE array.
- Adds what the earlier cache lacked: full/empty flow control, occupancy count, 1-cycle registered read with valid, and error flags.
- Adds a retain/rewind window so kernel rows can be replayed without reloading.
- Emits window index tags (row, 3x3 group) aligned with each read word.

Parameters:
- DATA_WIDTH, 128, bits per cached row word.
- DEPTH, 64, number of entries; must be a power of two, >=4.
- ADDR_WIDTH, 6, log2(DEPTH).
- ROW_LEN, 16, words per activation row; used for index tags.
- KERNEL, 3, kernel width; used for group tag.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  global enable; when 0 all state holds and no request is accepted
- wr_req  in  1  write request
- wr_data  in  DATA_WIDTH  write word
- wr_ready  out  1  not full
- rd_req  in  1  read request
- rd_ready  out  1  not empty (rd != wr)
- rd_valid  out  1  rd_data valid this cycle
- rd_data  out  DATA_WIDTH  read word
- rd_row_idx  out  ADDR_WIDTH  row tag, = read address / ROW_LEN
- rd_grp_idx  out  ADDR_WIDTH  group tag, = (read address % ROW_LEN) / KERNEL
- release_req  in  1  free retained entries: base <= rd
- rewind_req  in  1  replay: rd <= base
- used_cnt  out  ADDR_WIDTH+1  entries held, = wr - base
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty
- clr_err  in  1  clears overflow/underflow

Behaviour:
- Reset is asynchronous on rst_n. Defined in the interface as: reset rst_n, asynchronous, active-low; clock clk.
- Reset values: wr/rd/base pointers = 0, rd_valid = 0, rd_data = 0, tags = 0, overflow = 0, underflow = 0, used_cnt = 0, wr_ready = 1, rd_ready = 0.
- Pointers are ADDR_WIDTH+1 bits; the MSB is the wrap bit. The memory address is pointer[ADDR_WIDTH-1:0].
- full = (wr - base) == DEPTH. Space is freed only by release, never by reading.
- Write accept = clk_en & wr_req & ~full. On accept: mem[wr] <= wr_data, wr++.
- Read accept = clk_en & rd_req & (rd != wr) & ~rewind_req. On accept: rd++.
- Read timing: the cycle after an accept, rd_valid = 1, rd_data = mem[old rd], and tags are computed from the old rd address (low ADDR_WIDTH bits). Read latency is 1.
- If no read is accepted, rd_valid = 0 next cycle and rd_data/tags hold.
- No write-to-read bypass: write and read in the same cycle on empty refuses the read. The word is readable from the next cycle.
- Release (clk_en): base <= rd. If a read is accepted in the same cycle, base <= rd+1 (post-read value).
- Rewind (clk_en): rd <= base. It has priority over the same-cycle read (read not accepted, underflow not set) and over release (release ignored).
- Rewind with rd == base is a no-op.
- Write is independent of rewind and release.
- Full and release in the same cycle: wr_ready reflects the pre-release state. The write is refused and overflow sets.
- Errors: overflow sets on clk_en & wr_req & full; underflow sets on clk_en & rd_req & empty & ~rewind_req. Both are sticky until clr_err. clr_err loses to a same-cycle set.
- clk_en = 0 freezes pointers, flags, and rd_valid/rd_data.
- Pointer wrap-around: unsigned modulo 2^(ADDR_WIDTH+1). The used_cnt subtraction is modulo and always lies in 0..DEPTH.
- wr_ready, rd_ready and used_cnt are combinational from the registered pointers.

Test Plan:
- Reset, then write 64 words (values 0..63) -> wr_ready drops after the 64th, used_cnt=64; 65th write refused, overflow=1.
- Read 5 words -> rd_valid one cycle after each accept, data 0..4. Tags for address 4: row_idx=0, grp_idx=1. Address 19: row_idx=1, grp_idx=1.
- Read 3, rewind, read 3 -> data 0,1,2,0,1,2; used_cnt unchanged at 64.
- Release after reading 16 -> used_cnt=48, wr_ready=1. Write 16 more -> pointers wrap and data at memory address 0 is the new word.
- On empty, assert wr_req and rd_req together -> read refused, underflow=1, rd_valid=0. Next-cycle read returns the written word.
- Hold clk_en=0 with all requests active for 4 cycles -> no pointer or flag change. Assert rst_n low mid-stream -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/act_row_cache.sv
// Activation row cache: circular buffer with a retain/rewind window, 1-cycle registered read,
// window index tags and sticky overflow/underflow flags.
module act_row_cache #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned ROW_LEN    = 16,
  parameter int unsigned KERNEL     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en_i,
  input  logic                  wr_req_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  wr_ready_o,
  input  logic                  rd_req_i,
  output logic                  rd_ready_o,
  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [ADDR_WIDTH-1:0] rd_row_idx_o,
  output logic [ADDR_WIDTH-1:0] rd_grp_idx_o,
  input  logic                  release_req_i,
  input  logic                  rewind_req_i,
  output logic [ADDR_WIDTH:0]   used_cnt_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
  input  logic                  clr_err_i
);

  localparam int unsigned PtrW = ADDR_WIDTH + 1;
  localparam logic [PtrW-1:0]       DepthP  = PtrW'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] RowLenA = ADDR_WIDTH'(ROW_LEN);
  localparam logic [ADDR_WIDTH-1:0] KernelA = ADDR_WIDTH'(KERNEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, base_q, base_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [ADDR_WIDTH-1:0] row_q, row_d, grp_q, grp_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;

  logic [PtrW-1:0]       used;
  logic                  full, empty, wr_acc, rd_acc;
  logic [ADDR_WIDTH-1:0] rd_addr;

  // Space is reclaimed only by release, so occupancy is measured from base, not rd.
  assign used    = wr_ptr_q - base_q;
  assign full    = (used == DepthP);
  assign empty   = (rd_ptr_q == wr_ptr_q);
  assign wr_acc  = clk_en_i & wr_req_i & ~full;
  assign rd_acc  = clk_en_i & rd_req_i & ~empty & ~rewind_req_i;
  assign rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    base_d      = base_q;
    rd_valid_d  = rd_valid_q;
    rd_data_d   = rd_data_q;
    row_d       = row_q;
    grp_d       = grp_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clk_en_i) begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PtrW'(1);
      // Rewind wins over both the same-cycle read and release.
      if (rewind_req_i) begin
        rd_ptr_d = base_q;
      end else begin
        if (rd_acc) rd_ptr_d = rd_ptr_q + PtrW'(1);
        if (release_req_i) base_d = rd_ptr_d;
      end
      rd_valid_d = rd_acc;
      if (rd_acc) begin
        rd_data_d = mem_q[rd_addr];
        row_d     = rd_addr / RowLenA;
        grp_d     = (rd_addr % RowLenA) / KernelA;
      end
      if (clr_err_i) begin
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
      end
      if (wr_req_i & full) overflow_d = 1'b1;
      if (rd_req_i & empty & ~rewind_req_i) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      base_q      <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      row_q       <= '0;
      grp_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      base_q      <= base_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      row_q       <= row_d;
      grp_q       <= grp_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data_i;
  end

  assign wr_ready_o   = ~full;
  assign rd_ready_o   = ~empty;
  assign used_cnt_o   = used;
  assign rd_valid_o   = rd_valid_q;
  assign rd_data_o    = rd_data_q;
  assign rd_row_idx_o = row_q;
  assign rd_grp_idx_o = grp_q;
  assign overflow_o   = overflow_q;
  assign underflow_o  = underflow_q;

endmodule

// File: tb/tb_act_row_cache.sv
// Bench for act_row_cache: phase table with hand-derived status, reference model feeding a
// scoreboard of expected read words/tags, and hand-written corner-case sequences.
module tb_act_row_cache;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clk_en, wr_req, rd_req, release_req, rewind_req, clr_err;
  logic [127:0] wr_data;
  logic         wr_ready, rd_ready, rd_valid, overflow, underflow;
  logic [127:0] rd_data;
  logic [5:0]   rd_row_idx, rd_grp_idx;
  logic [6:0]   used_cnt;

  act_row_cache dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_en_i     (clk_en),
    .wr_req_i     (wr_req),
    .wr_data_i    (wr_data),
    .wr_ready_o   (wr_ready),
    .rd_req_i     (rd_req),
    .rd_ready_o   (rd_ready),
    .rd_valid_o   (rd_valid),
    .rd_data_o    (rd_data),
    .rd_row_idx_o (rd_row_idx),
    .rd_grp_idx_o (rd_grp_idx),
    .release_req_i(release_req),
    .rewind_req_i (rewind_req),
    .used_cnt_o   (used_cnt),
    .overflow_o   (overflow),
    .underflow_o  (underflow),
    .clr_err_i    (clr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic [5:0]   row;
    logic [5:0]   grp;
  } exp_t;

  typedef struct {
    int n_wr; int n_rd; bit rel; bit rew; bit clr;
    int used; bit wr_rdy; bit rd_rdy; bit ovf; bit unf; int row; int grp;
  } vec_t;

  exp_t         exp_q[$];
  logic [127:0] m_mem [64];
  logic [6:0]   m_wr, m_rd, m_base;
  bit           m_valid, m_ovf, m_unf;
  logic [127:0] m_data;
  logic [5:0]   m_row, m_grp;
  int           n_checks = 0;
  int           n_fail = 0;
  int           wseq = 0;
  logic [127:0] xword;
  vec_t         vecs [13];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_wr = '0; m_rd = '0; m_base = '0;
    m_valid = 0; m_ovf = 0; m_unf = 0;
    m_data = '0; m_row = '0; m_grp = '0;
    exp_q.delete();
  endtask

  task automatic check_outputs(input bit en);
    exp_t e;
    logic [6:0] u;
    u = m_wr - m_base;
    chk("used_cnt", 128'(used_cnt), 128'(u));
    chk("wr_ready", 128'(wr_ready), 128'(u != 7'd64));
    chk("rd_ready", 128'(rd_ready), 128'(m_rd != m_wr));
    chk("overflow", 128'(overflow), 128'(m_ovf));
    chk("underflow", 128'(underflow), 128'(m_unf));
    chk("rd_valid", 128'(rd_valid), 128'(m_valid));
    if (en && m_valid) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 128'(1), 128'(0));
      end else begin
        e = exp_q.pop_front();
        m_data = e.data; m_row = e.row; m_grp = e.grp;
      end
    end
    chk("rd_data", rd_data, m_data);
    chk("rd_row_idx", 128'(rd_row_idx), 128'(m_row));
    chk("rd_grp_idx", 128'(rd_grp_idx), 128'(m_grp));
  endtask

  task automatic step(input bit en, input bit wr, input logic [127:0] wd, input bit rd,
                      input bit rel, input bit rew, input bit clr);
    logic [6:0] u;
    logic [5:0] a;
    bit full, empty, wacc, racc;
    exp_t e;
    clk_en = en; wr_req = wr; wr_data = wd; rd_req = rd;
    release_req = rel; rewind_req = rew; clr_err = clr;
    u = m_wr - m_base;
    full = (u == 7'd64);
    empty = (m_rd == m_wr);
    wacc = en && wr && !full;
    racc = en && rd && !empty && !rew;
    if (en) begin
      if (racc) begin
        a = m_rd[5:0];
        e.data = m_mem[a];
        e.row = a >> 4;
        e.grp = (a & 6'd15) / 6'd3;
        exp_q.push_back(e);
      end
      if (clr) begin m_ovf = 0; m_unf = 0; end
      if (wr && full) m_ovf = 1;
      if (rd && empty && !rew) m_unf = 1;
      if (wacc) begin m_mem[m_wr[5:0]] = wd; m_wr = m_wr + 7'd1; end
      if (rew) m_rd = m_base;
      else begin
        if (racc) m_rd = m_rd + 7'd1;
        if (rel) m_base = m_rd;
      end
      m_valid = racc;
    end
    @(posedge clk);
    #1;
    clk_en = 1; wr_req = 0; rd_req = 0; release_req = 0; rewind_req = 0; clr_err = 0;
    check_outputs(en);
  endtask

  task automatic wr1();
    step(1, 1, 128'(wseq), 0, 0, 0, 0);
    wseq++;
  endtask

  task automatic rd1();
    step(1, 0, '0, 1, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //          wr  rd  rel rew clr used wr_r rd_r ovf unf row grp
    vecs[0]  = '{64, 0,  0,  0,  0,  64,  0,   1,   0,  0, -1, -1};
    vecs[1]  = '{1,  0,  0,  0,  0,  64,  0,   1,   1,  0, -1, -1};
    vecs[2]  = '{0,  5,  0,  0,  0,  64,  0,   1,   1,  0,  0,  1};
    vecs[3]  = '{0,  0,  0,  1,  0,  64,  0,   1,   1,  0, -1, -1};
    vecs[4]  = '{0,  3,  0,  0,  0,  64,  0,   1,   1,  0,  0,  0};
    vecs[5]  = '{0,  0,  0,  1,  0,  64,  0,   1,   1,  0, -1, -1};
    vecs[6]  = '{0,  3,  0,  0,  0,  64,  0,   1,   1,  0,  0,  0};
    vecs[7]  = '{0,  0,  0,  1,  0,  64,  0,   1,   1,  0, -1, -1};
    vecs[8]  = '{0, 16,  1,  0,  0,  48,  1,   1,   1,  0, -1, -1};
    vecs[9]  = '{0,  4,  0,  0,  0,  48,  1,   1,   1,  0,  1,  1};
    vecs[10] = '{16, 0,  0,  0,  0,  64,  0,   1,   1,  0, -1, -1};
    vecs[11] = '{0, 60,  0,  0,  0,  64,  0,   0,   1,  0, -1, -1};
    vecs[12] = '{0,  0,  1,  0,  1,   0,  1,   0,   0,  0, -1, -1};

    rst_n = 0; clk_en = 1; wr_req = 0; rd_req = 0; release_req = 0; rewind_req = 0;
    clr_err = 0; wr_data = '0;
    model_reset();
    #12;
    rst_n = 1;
    chk("reset_used", 128'(used_cnt), 128'(0));
    chk("reset_wr_ready", 128'(wr_ready), 128'(1));
    chk("reset_rd_ready", 128'(rd_ready), 128'(0));
    chk("reset_rd_valid", 128'(rd_valid), 128'(0));
    chk("reset_rd_data", rd_data, 128'(0));
    chk("reset_flags", 128'({overflow, underflow}), 128'(0));

    for (int v = 0; v < 13; v++) begin
      for (int i = 0; i < vecs[v].n_wr; i++) wr1();
      for (int i = 0; i < vecs[v].n_rd; i++) rd1();
      if (vecs[v].rel || vecs[v].rew || vecs[v].clr)
        step(1, 0, '0, 0, vecs[v].rel, vecs[v].rew, vecs[v].clr);
      chk($sformatf("vec%0d_used", v), 128'(used_cnt), 128'(vecs[v].used));
      chk($sformatf("vec%0d_wr_ready", v), 128'(wr_ready), 128'(vecs[v].wr_rdy));
      chk($sformatf("vec%0d_rd_ready", v), 128'(rd_ready), 128'(vecs[v].rd_rdy));
      chk($sformatf("vec%0d_overflow", v), 128'(overflow), 128'(vecs[v].ovf));
      chk($sformatf("vec%0d_underflow", v), 128'(underflow), 128'(vecs[v].unf));
      if (vecs[v].row >= 0) begin
        chk($sformatf("vec%0d_row", v), 128'(rd_row_idx), 128'(vecs[v].row));
        chk($sformatf("vec%0d_grp", v), 128'(rd_grp_idx), 128'(vecs[v].grp));
      end
    end

    // Simultaneous write and read on empty: read refused, word readable next cycle.
    xword = 128'(wseq);
    step(1, 1, xword, 1, 0, 0, 0);
    wseq++;
    chk("empty_wr_rd_underflow", 128'(underflow), 128'(1));
    chk("empty_wr_rd_valid", 128'(rd_valid), 128'(0));
    rd1();
    chk("empty_next_rd_data", rd_data, xword);

    // clk_en low with every request active holds all state.
    for (int i = 0; i < 4; i++) step(0, 1, 128'hDEAD, 1, 1, 1, 1);
    chk("freeze_rd_valid", 128'(rd_valid), 128'(1));
    chk("freeze_rd_data", rd_data, xword);
    chk("freeze_used", 128'(used_cnt), 128'(1));
    chk("freeze_underflow", 128'(underflow), 128'(1));

    // Full and release together: write refused against pre-release occupancy.
    for (int i = 0; i < 63; i++) wr1();
    chk("refill_full", 128'(wr_ready), 128'(0));
    step(1, 1, 128'(wseq), 0, 1, 0, 0);
    chk("full_rel_used", 128'(used_cnt), 128'(63));
    chk("full_rel_overflow", 128'(overflow), 128'(1));
    wr1();
    chk("after_rel_used", 128'(used_cnt), 128'(64));

    // Rewind beats same-cycle read and release; read+release frees the post-read entry.
    rd1();
    rd1();
    step(1, 0, '0, 1, 1, 1, 0);
    chk("rewind_rd_valid", 128'(rd_valid), 128'(0));
    chk("rewind_used", 128'(used_cnt), 128'(64));
    rd1();
    step(1, 0, '0, 1, 1, 0, 0);
    chk("rd_rel_used", 128'(used_cnt), 128'(62));

    // Asynchronous reset between clock edges.
    #3;
    rst_n = 0;
    #1;
    chk("async_rst_used", 128'(used_cnt), 128'(0));
    chk("async_rst_wr_ready", 128'(wr_ready), 128'(1));
    chk("async_rst_rd_ready", 128'(rd_ready), 128'(0));
    chk("async_rst_rd_valid", 128'(rd_valid), 128'(0));
    chk("async_rst_rd_data", rd_data, 128'(0));
    chk("async_rst_tags", 128'({rd_row_idx, rd_grp_idx}), 128'(0));
    chk("async_rst_flags", 128'({overflow, underflow}), 128'(0));
    #1;
    rst_n = 1;
    model_reset();
    wr1();
    rd1();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
